// File: rtl/dpd_pkg.sv
// Shared DPD datapath definitions: default component width, Q1.(W-1) limits
// and the complex-divider state encoding.
package dpd_pkg;

    localparam int DPD_W = 20;
    localparam int Q_MAX = (1 << (DPD_W - 1)) - 1;
    localparam int Q_MIN = -(1 << (DPD_W - 1));

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_DIV,
        ST_RND,
        ST_DONE
    } cdiv_state_t;

endpackage

// File: rtl/udiv_seq.sv
// Unsigned restoring divider: quotient = floor(num * 2^W / den), one bit per cycle.
// Loads on start, W steps later quotient is final; done flags the last step.
module udiv_seq
    import dpd_pkg::*;
#(
    parameter int W = DPD_W
) (
    input  logic           clk,
    input  logic           reset_b,
    input  logic           start,
    input  logic [2*W-1:0] numerator,
    input  logic [2*W-1:0] denominator,
    output logic [W-1:0]   quotient,
    output logic           done
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] rem_q, rem_d;
    logic [2*W-1:0] den_q;
    logic [W-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [2*W:0]   shifted;
    logic           take;

    // Remainder stays below den whenever num < den, so 2W bits are enough.
    always_comb begin
        shifted = {rem_q, 1'b0};
        take    = (shifted >= {1'b0, den_q});
        rem_d   = take ? (shifted[2*W-1:0] - den_q) : shifted[2*W-1:0];
        quo_d   = {quo_q[W-2:0], take};
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            rem_q  <= numerator;
            den_q  <= denominator;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST)
                busy_q <= 1'b0;
        end
    end

    assign quotient = quo_q;
    assign done     = busy_q && (cnt_q == LAST);

endmodule

// File: rtl/compl_div.sv
// Sequential complex divider o = a / b in Q1.(W-1); result W+2 cycles after accept.
// Single operation in flight: in_ready only in IDLE, result held until out_ready.
module compl_div
    import dpd_pkg::*;
#(
    parameter int W = DPD_W
) (
    input  logic           clk,
    input  logic           reset_b,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] o,
    output logic           ovf,
    output logic           dz
);

    localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

    cdiv_state_t    state_q;
    logic [2*W-1:0] opa_q, opb_q;
    logic           neg_i_q, neg_q_q, sat_i_q, sat_q_q, dzp_q;
    logic [2*W-1:0] res_q;
    logic           ovf_q, dz_q, out_valid_q;

    logic signed [2*W:0]   ai, aq, bi, bq, n_i, n_q;
    logic signed [2*W-1:0] bi_w, bq_w;
    logic [2*W-1:0]        den_c;
    logic [2*W:0]          mag_i, mag_q;
    logic [W-1:0]          quo_i, quo_q;
    logic                  done_i, done_q, div_start;
    logic [W:0]            rnd_i, rnd_q;

    // Returns {overflow, component}; magnitude rounding is half away from zero.
    function automatic logic [W:0] rnd_sat(input logic [W-1:0] q, input logic neg,
                                           input logic sat);
        logic [W-1:0] m;
        m = {1'b0, q[W-1:1]} + {{(W-1){1'b0}}, q[0]};
        if (sat)
            return {1'b1, neg ? SAT_NEG : SAT_POS};
        else if (neg)
            return {1'b0, -m};
        else if (m[W-1])
            return {1'b1, SAT_POS};
        else
            return {1'b0, m};
    endfunction

    always_comb begin
        ai    = {{(W+1){opa_q[2*W-1]}}, opa_q[2*W-1:W]};
        aq    = {{(W+1){opa_q[W-1]}},   opa_q[W-1:0]};
        bi    = {{(W+1){opb_q[2*W-1]}}, opb_q[2*W-1:W]};
        bq    = {{(W+1){opb_q[W-1]}},   opb_q[W-1:0]};
        bi_w  = {{W{opb_q[2*W-1]}}, opb_q[2*W-1:W]};
        bq_w  = {{W{opb_q[W-1]}},   opb_q[W-1:0]};
        n_i   = ai * bi + aq * bq;
        n_q   = aq * bi - ai * bq;
        den_c = bi_w * bi_w + bq_w * bq_w;
        mag_i = n_i[2*W] ? -n_i : n_i;
        mag_q = n_q[2*W] ? -n_q : n_q;
        rnd_i = rnd_sat(quo_i, neg_i_q, sat_i_q);
        rnd_q = rnd_sat(quo_q, neg_q_q, sat_q_q);
    end

    assign div_start = (state_q == ST_PREP);

    udiv_seq #(.W(W)) u_div_i (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (div_start),
        .numerator  (mag_i[2*W-1:0]),
        .denominator(den_c),
        .quotient   (quo_i),
        .done       (done_i)
    );

    udiv_seq #(.W(W)) u_div_q (
        .clk        (clk),
        .reset_b    (reset_b),
        .start      (div_start),
        .numerator  (mag_q[2*W-1:0]),
        .denominator(den_c),
        .quotient   (quo_q),
        .done       (done_q)
    );

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q     <= ST_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            neg_i_q     <= 1'b0;
            neg_q_q     <= 1'b0;
            sat_i_q     <= 1'b0;
            sat_q_q     <= 1'b0;
            dzp_q       <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (in_valid) begin
                    opa_q   <= a;
                    opb_q   <= b;
                    state_q <= ST_PREP;
                end
                ST_PREP: begin
                    neg_i_q <= n_i[2*W];
                    neg_q_q <= n_q[2*W];
                    sat_i_q <= (mag_i >= {1'b0, den_c});
                    sat_q_q <= (mag_q >= {1'b0, den_c});
                    dzp_q   <= (den_c == '0);
                    state_q <= ST_DIV;
                end
                ST_DIV: if (done_i && done_q)
                    state_q <= ST_RND;
                ST_RND: begin
                    res_q       <= dzp_q ? '0 : {rnd_i[W-1:0], rnd_q[W-1:0]};
                    ovf_q       <= !dzp_q && (rnd_i[W] || rnd_q[W]);
                    dz_q        <= dzp_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign o         = res_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
